// File: rtl/dmem_bus_arbiter.sv
// Round-robin, non-preemptive arbiter for the MiniRISC data-memory bus.
// Optional CPU priority, one-cycle turnaround gap between owners, and an overlong-hold watchdog.
module dmem_bus_arbiter #(
    parameter int unsigned  NUM_MASTERS  = 4,
    parameter int unsigned  CPU_PRIORITY = 1,
    parameter int unsigned  MAX_HOLD     = 32,
    localparam int unsigned OWNER_W      = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] bus_req,
    output logic [NUM_MASTERS-1:0] bus_grant,
    output logic [OWNER_W-1:0]     bus_owner,
    output logic                   bus_busy,
    output logic                   hold_timeout,
    input  logic                   timeout_clr
);

    localparam int unsigned RR_LO  = (CPU_PRIORITY != 0) ? 1 : 0;
    localparam int unsigned RR_NUM = NUM_MASTERS - RR_LO;
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [OWNER_W-1:0] RR_FIRST  = OWNER_W'(RR_LO);
    localparam logic [OWNER_W:0]   NUM_EXT   = (OWNER_W + 1)'(NUM_MASTERS);
    localparam logic [OWNER_W:0]   RR_EXT    = (OWNER_W + 1)'(RR_NUM);

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        GAP
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_d;
    logic [OWNER_W-1:0]       owner_d;
    logic [OWNER_W-1:0]       rr_q, rr_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic                     timeout_d;

    logic                     win_valid;
    logic [OWNER_W-1:0]       win_idx;
    logic [OWNER_W-1:0]       win_next;
    logic [OWNER_W:0]         scan;
    logic [OWNER_W:0]         next_ext;

    // Winner: CPU first when prioritised, else first requester at or above rr_q, wrapping in the set.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan      = '0;
        if (CPU_PRIORITY != 0 && bus_req[0]) begin
            win_valid = 1'b1;
        end else begin
            for (int unsigned i = 0; i < RR_NUM; i++) begin
                scan = {1'b0, rr_q} + (OWNER_W + 1)'(i);
                if (scan >= NUM_EXT) begin
                    scan = scan - RR_EXT;
                end
                if (!win_valid && bus_req[scan[OWNER_W-1:0]]) begin
                    win_valid = 1'b1;
                    win_idx   = scan[OWNER_W-1:0];
                end
            end
        end
    end

    always_comb begin
        next_ext = {1'b0, win_idx} + 1'b1;
        if (next_ext >= NUM_EXT) begin
            win_next = RR_FIRST;
        end else begin
            win_next = next_ext[OWNER_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = bus_grant;
        owner_d   = bus_owner;
        rr_d      = rr_q;
        hold_d    = hold_q;
        timeout_d = hold_timeout & ~timeout_clr;

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    hold_d           = HOLD_W'(1);
                    state_d          = GRANTED;
                    if (!(CPU_PRIORITY != 0 && win_idx == '0)) begin
                        rr_d = win_next;
                    end
                end
            end
            GRANTED: begin
                if (bus_req[bus_owner]) begin
                    // hold_q counts owner cycles including the current one; set wins over clear.
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                    if (hold_q == HOLD_LAST) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    grant_d = '0;
                    owner_d = '0;
                    hold_d  = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bus_grant    <= '0;
            bus_owner    <= '0;
            bus_busy     <= 1'b0;
            hold_timeout <= 1'b0;
            rr_q         <= RR_FIRST;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            bus_grant    <= grant_d;
            bus_owner    <= owner_d;
            bus_busy     <= |grant_d;
            hold_timeout <= timeout_d;
            rr_q         <= rr_d;
            hold_q       <= hold_d;
        end
    end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Scoreboard bench for dmem_bus_arbiter: a behavioural model queues expected outputs per cycle,
// a monitor pops and compares them; directed scenarios plus a random request storm.
module tb_dmem_bus_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned CPUP = 1;
    localparam int unsigned MAXH = 32;
    localparam int unsigned OW   = 2;
    localparam int LO  = (CPUP != 0) ? 1 : 0;
    localparam int RRN = N - LO;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          timeout_clr = 1'b0;
    logic [N-1:0]  bus_req = '0;
    logic [N-1:0]  bus_grant;
    logic [OW-1:0] bus_owner;
    logic          bus_busy;
    logic          hold_timeout;

    always #5 clk = ~clk;

    dmem_bus_arbiter #(
        .NUM_MASTERS (N),
        .CPU_PRIORITY(CPUP),
        .MAX_HOLD    (MAXH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_req     (bus_req),
        .bus_grant   (bus_grant),
        .bus_owner   (bus_owner),
        .bus_busy    (bus_busy),
        .hold_timeout(hold_timeout),
        .timeout_clr (timeout_clr)
    );

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [OW-1:0] owner;
        logic          busy;
        logic          to;
    } exp_t;

    exp_t expq[$];
    int   obs[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: current owner (-1 none), turnaround pending, next round-robin candidate,
    // cycles owned so far, sticky watchdog flag.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_rr    = LO;
    int m_held  = 0;
    bit m_to    = 1'b0;

    function automatic int pick(input logic [N-1:0] r);
        if (CPUP != 0 && r[0]) return 0;
        for (int k = 0; k < RRN; k++) begin
            int c;
            c = LO + ((m_rr - LO + k) % RRN);
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic c, input logic rs);
        exp_t e;
        bit   setnow;
        int   w;
        setnow = 1'b0;
        if (rs) begin
            m_owner = -1; m_gap = 1'b0; m_rr = LO; m_held = 0; m_to = 1'b0;
        end else if (m_owner >= 0) begin
            if (r[m_owner]) begin
                m_held++;
                setnow = (m_held == MAXH);
            end else begin
                m_owner = -1; m_gap = 1'b1; m_held = 0;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            w = pick(r);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                if (!(CPUP != 0 && w == 0)) m_rr = (w + 1 >= N) ? LO : w + 1;
            end
        end
        if (!rs) m_to = setnow ? 1'b1 : (c ? 1'b0 : m_to);
        e.grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.owner = (m_owner >= 0) ? OW'(m_owner) : '0;
        e.busy  = (m_owner >= 0);
        e.to    = m_to;
        expq.push_back(e);
    endtask

    task automatic tick(input logic [N-1:0] r, input logic c, input logic rs);
        bus_req     = r;
        timeout_clr = c;
        rst         = rs;
        @(posedge clk);
        model_step(r, c, rs);
        @(negedge clk);
    endtask

    // Monitor: compare every registered output set against the queued expectation.
    initial begin
        exp_t         e;
        logic [N-1:0] prev_g;
        prev_g = '0;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                total++;
                if ({bus_grant, bus_owner, bus_busy, hold_timeout} !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got grant=%b owner=%0d busy=%b to=%b want grant=%b owner=%0d busy=%b to=%b",
                             $time, bus_grant, bus_owner, bus_busy, hold_timeout, e.grant, e.owner, e.busy, e.to);
                end
                total++;
                if ($countones(bus_grant) > 1) begin
                    bad++;
                    $display("FAIL onehot t=%0t got grant=%b want at most one bit", $time, bus_grant);
                end
                if (bus_grant != '0 && prev_g == '0) obs.push_back(int'(bus_owner));
                prev_g = bus_grant;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Request driver: masters hold req until served for dur cycles of grant.
    bit           want[N];
    bit           rearm[N];
    int           dur[N];
    int           gcnt[N];
    int           skips[N];
    bit           refill    = 1'b0;
    int           raise_pct = 0;
    logic [N-1:0] drv_prev  = '0;

    task automatic raise(input int m, input int d);
        want[m] = 1'b1; dur[m] = d; gcnt[m] = 0; skips[m] = 0; rearm[m] = 1'b0;
    endtask

    task automatic step_drv(input logic clr);
        logic [N-1:0] r;
        int           o;
        if (bus_grant != '0 && drv_prev == '0) begin
            o = int'(bus_owner);
            for (int m = 0; m < N; m++) begin
                if (want[m]) begin
                    if (m != o && !(CPUP != 0 && o == 0)) skips[m]++;
                    total++;
                    if (skips[m] > N - 1) begin
                        bad++;
                        $display("FAIL fairness master=%0d got skipped=%0d want at most %0d", m, skips[m], N - 1);
                    end
                    if (m == o) skips[m] = 0;
                end
            end
        end
        drv_prev = bus_grant;
        for (int m = 0; m < N; m++) begin
            if (want[m]) begin
                if (m == m_owner) begin
                    gcnt[m]++;
                    if (gcnt[m] >= dur[m]) begin
                        want[m]  = 1'b0;
                        rearm[m] = refill;
                    end
                end
            end else if (rearm[m]) begin
                rearm[m] = 1'b0; want[m] = 1'b1; gcnt[m] = 0; skips[m] = 0;
            end else if (raise_pct != 0 && $urandom_range(99) < raise_pct) begin
                raise(m, ($urandom_range(29) == 0) ? 34 + $urandom_range(8) : 1 + $urandom_range(5));
            end
        end
        for (int m = 0; m < N; m++) r[m] = want[m];
        tick(r, clr, 1'b0);
    endtask

    task automatic run(input int n);
        repeat (n) step_drv(1'b0);
    endtask

    task automatic do_reset();
        logic [N-1:0] r;
        for (int m = 0; m < N; m++) r[m] = want[m];
        tick(r, 1'b0, 1'b1);
        for (int m = 0; m < N; m++) begin
            want[m] = 1'b0; rearm[m] = 1'b0;
        end
    endtask

    task automatic check_order(input string name, input int idx, input int exp_m);
        total++;
        if (obs.size() <= idx || obs[idx] != exp_m) begin
            bad++;
            $display("FAIL %s got owner=%0d want owner=%0d", name, (obs.size() > idx) ? obs[idx] : -1, exp_m);
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, exp_v);
        end
    endtask

    initial begin
        for (int m = 0; m < N; m++) begin
            want[m] = 1'b0; rearm[m] = 1'b0; dur[m] = 1; gcnt[m] = 0; skips[m] = 0;
        end
        @(negedge clk);
        do_reset();
        do_reset();
        check_val("reset_grant", 8'(bus_grant), 8'h00);

        // Single CPU access: grant in cycles 1..3.
        obs.delete();
        raise(0, 3);
        run(8);
        check_order("t1_first", 0, 0);
        check_val("t1_count", 8'(obs.size()), 8'd1);

        // Round-robin with re-requesting masters.
        obs.delete();
        refill = 1'b1;
        raise(1, 2); raise(2, 2); raise(3, 2);
        run(16);
        refill = 1'b0;
        run(15);
        check_order("t2_o0", 0, 1);
        check_order("t2_o1", 1, 2);
        check_order("t2_o2", 2, 3);
        check_order("t2_o3", 3, 1);

        // No preemption; CPU served next, ahead of pending master 3.
        obs.delete();
        raise(2, 6);
        run(2);
        raise(0, 3); raise(3, 3);
        run(25);
        check_order("t3_o0", 0, 2);
        check_order("t3_o1", 1, 0);
        check_order("t3_o2", 2, 3);

        // Watchdog on a long hold, then cleared while still held.
        obs.delete();
        raise(1, 40);
        run(34);
        check_val("t4_timeout_set", 8'(hold_timeout), 8'd1);
        check_val("t4_grant_kept", 8'(bus_grant), 8'b0010);
        step_drv(1'b1);
        check_val("t4_timeout_clr", 8'(hold_timeout), 8'd0);
        run(15);

        // Reset mid-grant, then req=1010.
        raise(3, 30);
        run(3);
        check_val("t5_pre_grant", 8'(bus_grant), 8'b1000);
        do_reset();
        check_val("t5_grant_rst", 8'(bus_grant), 8'h00);
        check_val("t5_owner_rst", 8'(bus_owner), 8'h00);
        obs.delete();
        raise(1, 2); raise(3, 2);
        run(10);
        check_order("t5_first", 0, 1);

        raise(2, 30);
        run(3);
        do_reset();
        obs.delete();
        raise(1, 2); raise(3, 2);
        run(10);
        check_order("t5b_first", 0, 1);

        // Random request storm with occasional clear pulses.
        raise_pct = 15;
        repeat (10000) step_drv($urandom_range(49) == 0);
        raise_pct = 0;
        run(300);

        #2;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got pending=%0d want 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
